// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide controller.
//   state_t         controller FSM states
//   SEL_*           HI_sel / LO_sel encodings
//   OP_EN / OP_SGN  bit positions inside the multiply / divide request fields
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV_RUN = 2'd2,
    DIV_FIX = 2'd3
  } state_t;

  localparam logic [1:0] SEL_RS   = 2'b00;  // mthi / mtlo from rs_data
  localparam logic [1:0] SEL_MUL  = 2'b01;
  localparam logic [1:0] SEL_DIV  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int OP_EN  = 1;
  localparam int OP_SGN = 0;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: decode-side request bundle and HI/LO result bundle.
//   master: decode/pipeline side (drives requests, reads hi/lo/stall)
//   slave : muldiv_ctrl side
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        multiply;
  logic [1:0]        divide;
  logic [1:0]        HI_sel;
  logic [1:0]        LO_sel;
  logic              mf_req;
  logic              flush;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              stall;
  logic              busy;
  logic              div_by_zero;

  modport master (
    output multiply, divide, HI_sel, LO_sel, mf_req, flush, rs_data, rt_data,
    input  hi, lo, stall, busy, div_by_zero
  );

  modport slave (
    input  multiply, divide, HI_sel, LO_sel, mf_req, flush, rs_data, rt_data,
    output hi, lo, stall, busy, div_by_zero
  );
endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// div_step: one combinational restoring shift-subtract division step.
//   rem_in   partial remainder from the previous step (always < divisor)
//   bit_in   next dividend bit shifted in (MSB first)
//   divisor  divisor magnitude
//   rem_out  new partial remainder
//   q_bit    quotient bit produced by this step
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);
  logic [DATA_W:0]   partial;
  logic [DATA_W+1:0] diff;
  logic              unused_diff_msb;

  assign partial = {rem_in, bit_in};
  // Extra top bit acts as the borrow: set means partial < divisor.
  assign diff    = {1'b0, partial} - {2'b00, divisor};
  assign q_bit   = ~diff[DATA_W+1];
  // partial < 2*divisor, so a successful subtract always fits in DATA_W bits
  // and a failed one leaves partial's top bit clear.
  assign rem_out = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
  assign unused_diff_msb = diff[DATA_W];
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO register controller with single-cycle multiply and an
// iterative restoring divider.
//   clk, rst  rising-edge clock, asynchronous active-high reset
//   bus       muldiv_ctrl_if.slave: multiply/divide requests, HI/LO selects,
//             mf_req, flush, operands in; hi, lo, stall, busy, div_by_zero out
module muldiv_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

  state_t            state;
  logic [DATA_W-1:0] hi_q, lo_q;
  // a_q: multiplicand, or dividend shifting out MSB-first while quotient
  // bits shift in at the bottom. b_q: multiplier, or divisor magnitude.
  logic [DATA_W-1:0] a_q, b_q, rem_q;
  logic [CW-1:0]     cnt_q;
  logic              mul_sgn_q, neg_quo_q, neg_rem_q;

  logic mul_req, div_req, mul_sgn, div_sgn, accept_ok;
  logic [DATA_W-1:0] rs_mag, rt_mag, step_rem, quo_fix, rem_fix;
  logic              step_q;
  logic [2*DATA_W-1:0] mul_a, mul_b, prod;

  assign mul_req   = bus.multiply[OP_EN];
  assign mul_sgn   = bus.multiply[OP_SGN];
  assign div_req   = bus.divide[OP_EN];
  assign div_sgn   = bus.divide[OP_SGN];
  assign accept_ok = (state == IDLE) && !bus.flush;

  assign rs_mag = (div_sgn && bus.rs_data[DATA_W-1]) ? -bus.rs_data : bus.rs_data;
  assign rt_mag = (div_sgn && bus.rt_data[DATA_W-1]) ? -bus.rt_data : bus.rt_data;

  // Extend to full width so one truncated multiply serves both signednesses.
  assign mul_a = mul_sgn_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
  assign mul_b = mul_sgn_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
  assign prod  = mul_a * mul_b;

  div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_in  (rem_q),
    .bit_in  (a_q[DATA_W-1]),
    .divisor (b_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign quo_fix = neg_quo_q ? -a_q : a_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy && (mul_req || div_req || bus.HI_sel == SEL_RS ||
                                  bus.LO_sel == SEL_RS || bus.mf_req);
  // Flagged in the cycle the request is presented; the divide is not started.
  assign bus.div_by_zero = !rst && accept_ok && !mul_req && div_req &&
                           (bus.rt_data == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      mul_sgn_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_ok) begin
            if (mul_req) begin
              a_q       <= bus.rs_data;
              b_q       <= bus.rt_data;
              mul_sgn_q <= mul_sgn;
              state     <= MUL;
            end else if (div_req) begin
              if (bus.rt_data != '0) begin
                a_q       <= rs_mag;
                b_q       <= rt_mag;
                rem_q     <= '0;
                cnt_q     <= '0;
                neg_quo_q <= div_sgn && (bus.rs_data[DATA_W-1] ^ bus.rt_data[DATA_W-1]);
                neg_rem_q <= div_sgn && bus.rs_data[DATA_W-1];
                state     <= DIV_RUN;
              end
            end else begin
              if (bus.HI_sel == SEL_RS) hi_q <= bus.rs_data;
              if (bus.LO_sel == SEL_RS) lo_q <= bus.rs_data;
            end
          end
        end
        MUL: begin
          if (!bus.flush) {hi_q, lo_q} <= prod;
          state <= IDLE;
        end
        DIV_RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            rem_q <= step_rem;
            a_q   <= {a_q[DATA_W-2:0], step_q};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (!bus.flush) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W     = 32;
  localparam int STEPS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.DATA_W(W)) bus ();
  muldiv_ctrl #(.DATA_W(W), .DIV_STEPS(STEPS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: latency countdown + plain arithmetic
  function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      return x * y;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  int         m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      if (bus.flush) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_rhi;
          m_lo <= m_rlo;
        end
      end
    end else if (!bus.flush) begin
      if (bus.multiply[1]) begin
        {m_rhi, m_rlo} <= mul_model(bus.multiply[0], bus.rs_data, bus.rt_data);
        m_left <= 1;
      end else if (bus.divide[1]) begin
        if (bus.rt_data != 0) begin
          {m_rhi, m_rlo} <= div_model(bus.divide[0], bus.rs_data, bus.rt_data);
          m_left <= STEPS + 1;
        end
      end else begin
        if (bus.HI_sel == SEL_RS) m_hi <= bus.rs_data;
        if (bus.LO_sel == SEL_RS) m_lo <= bus.rs_data;
      end
    end
  end

  always @(negedge clk) begin
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("busy", bus.busy, m_left > 0);
    chk("stall", bus.stall, (m_left > 0) && (bus.multiply[1] || bus.divide[1] ||
        bus.HI_sel == SEL_RS || bus.LO_sel == SEL_RS || bus.mf_req));
    chk("div_by_zero", bus.div_by_zero, !rst && m_left == 0 && !bus.flush &&
        !bus.multiply[1] && bus.divide[1] && bus.rt_data == 0);
  end

  // ---------------- stimulus helpers
  task automatic idle_in();
    bus.multiply = 2'b00;
    bus.divide   = 2'b00;
    bus.HI_sel   = SEL_NONE;
    bus.LO_sel   = SEL_NONE;
    bus.mf_req   = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input logic [1:0] mul, input logic [1:0] dv, input logic [31:0] a, input logic [31:0] b);
    bus.multiply = mul;
    bus.divide   = dv;
    bus.rs_data  = a;
    bus.rt_data  = b;
    cyc(1);
    bus.multiply = 2'b00;
    bus.divide   = 2'b00;
  endtask

  // Counts busy cycles until the first idle negedge, then resyncs after the next edge.
  task automatic wait_idle(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
      else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after 200 cycles, required 0", bus.busy);
    end
    @(posedge clk);
    #1;
  endtask

  // Waits for the first negedge with stall low; leaves the bench at that negedge.
  task automatic wait_unstall(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.stall) done = 1;
      else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_unstall: stall still %b after 200 cycles, required 0", bus.stall);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    idle_in();
    bus.rs_data = '0;
    bus.rt_data = '0;
    rst = 1'b1;
    cyc(2);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // mthi then mtlo, no busy time
    bus.HI_sel = SEL_RS; bus.rs_data = 32'hAAAA_0001; cyc(1);
    bus.HI_sel = SEL_NONE; bus.LO_sel = SEL_RS; bus.rs_data = 32'h5555_0002; cyc(1);
    bus.LO_sel = SEL_NONE;
    chk("mthi", bus.hi, 32'hAAAA_0001);
    chk("mtlo", bus.lo, 32'h5555_0002);

    op(2'b11, 2'b00, 32'hFFFF_FFFE, 32'd3); wait_idle(n);
    chk("mult_busy", n, 1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    op(2'b10, 2'b00, 32'hFFFF_FFFE, 32'd3); wait_idle(n);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    op(2'b00, 2'b11, -32'sd7, 32'd2); wait_idle(n);
    chk("div_busy", n, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    op(2'b00, 2'b10, 32'd100, 32'd7); wait_idle(n);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    op(2'b00, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(n);
    chk("divmin_lo", bus.lo, 32'h8000_0000);
    chk("divmin_hi", bus.hi, 32'h0);

    // divide by zero: pulse in the presenting cycle, nothing else changes
    bus.divide = 2'b11; bus.rs_data = 32'd5; bus.rt_data = 32'd0;
    @(negedge clk);
    chk("dbz_pulse", bus.div_by_zero, 1);
    @(posedge clk); #1;
    bus.divide = 2'b00;
    @(negedge clk);
    chk("dbz_clear", bus.div_by_zero, 0);
    chk("dbz_busy", bus.busy, 0);
    chk("dbz_lo", bus.lo, 32'h8000_0000);
    @(posedge clk); #1;

    // mf_req from step 5 of a divu: stalls through DIV_FIX, then sees new hi/lo
    op(2'b00, 2'b10, 32'd1000, 32'd33);
    cyc(5);
    bus.mf_req = 1'b1;
    wait_unstall(n);
    chk("mf_stall_cycles", n, 28);
    chk("mf_lo", bus.lo, 32'd30);
    chk("mf_hi", bus.hi, 32'd10);
    @(posedge clk); #1;
    bus.mf_req = 1'b0;

    // flush at step 10: hi/lo untouched, next mult normal
    op(2'b00, 2'b11, 32'd12345, 32'd7);
    cyc(10);
    bus.flush = 1'b1; cyc(1); bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", bus.busy, 0);
    chk("flush_hi", bus.hi, 32'd10);
    chk("flush_lo", bus.lo, 32'd30);
    @(posedge clk); #1;
    op(2'b11, 2'b00, 32'd7, 32'hFFFF_FFFD); wait_idle(n);
    chk("post_flush_hi", bus.hi, 32'hFFFF_FFFF);
    chk("post_flush_lo", bus.lo, 32'hFFFF_FFEB);

    // flush in IDLE blocks acceptance
    bus.flush = 1'b1; bus.multiply = 2'b11; bus.rs_data = 32'd3; bus.rt_data = 32'd3;
    cyc(1);
    bus.flush = 1'b0; bus.multiply = 2'b00;
    @(negedge clk);
    chk("idle_flush_busy", bus.busy, 0);
    chk("idle_flush_lo", bus.lo, 32'hFFFF_FFEB);
    @(posedge clk); #1;

    // mthi held while a divu runs: ignored until the first IDLE cycle
    op(2'b00, 2'b10, 32'd50, 32'd5);
    bus.HI_sel = SEL_RS; bus.rs_data = 32'h0000_BEEF;
    wait_unstall(n);
    chk("held_stall_cycles", n, 33);
    @(posedge clk); #1;
    bus.HI_sel = SEL_NONE;
    chk("held_hi", bus.hi, 32'h0000_BEEF);
    chk("held_lo", bus.lo, 32'd10);

    // reset mid-DIV_RUN clears everything at once
    op(2'b00, 2'b11, 32'd1000, 32'd3);
    cyc(8);
    bus.mf_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_hi", bus.hi, 0);
    chk("rst_mid_lo", bus.lo, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_dbz", bus.div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mf_req = 1'b0;
    bus.HI_sel = SEL_RS; bus.rs_data = 32'h0000_1234; cyc(1);
    bus.HI_sel = SEL_NONE;
    chk("post_rst_mthi", bus.hi, 32'h0000_1234);
    op(2'b00, 2'b10, 32'd9, 32'd4); wait_idle(n);
    chk("post_rst_div_busy", n, 33);
    chk("post_rst_lo", bus.lo, 32'd2);
    chk("post_rst_hi", bus.hi, 32'd1);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
